// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: performs loads/stores over a req/ack bus
// and hands a registered write-back slot to WB. Non-memory ops pass through in one cycle.
module mem_access_stage #(
   parameter int ALUOP_W = 8,
   parameter int TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               valid_i,
   input  logic [ALUOP_W-1:0] aluop_i,
   input  logic [4:0]         wd_i,
   input  logic               wreg_i,
   input  logic [31:0]        wdata_i,
   input  logic [31:0]        mem_addr_i,
   input  logic [31:0]        reg2_i,
   output logic               stall_o,
   output logic               bus_req_o,
   output logic               bus_we_o,
   output logic [31:0]        bus_addr_o,
   output logic [3:0]         bus_be_o,
   output logic [31:0]        bus_wdata_o,
   input  logic [31:0]        bus_rdata_i,
   input  logic               bus_ack_i,
   output logic               wb_valid_o,
   output logic [4:0]         wb_wd_o,
   output logic               wb_wreg_o,
   output logic [31:0]        wb_wdata_o,
   output logic               addr_err_o,
   output logic               bus_err_o
);

   localparam logic [ALUOP_W-1:0] OP_LB  = ALUOP_W'(8'b1110_0000);
   localparam logic [ALUOP_W-1:0] OP_LBU = ALUOP_W'(8'b1110_0100);
   localparam logic [ALUOP_W-1:0] OP_LH  = ALUOP_W'(8'b1110_0001);
   localparam logic [ALUOP_W-1:0] OP_LHU = ALUOP_W'(8'b1110_0101);
   localparam logic [ALUOP_W-1:0] OP_LW  = ALUOP_W'(8'b1110_0011);
   localparam logic [ALUOP_W-1:0] OP_SB  = ALUOP_W'(8'b1110_1000);
   localparam logic [ALUOP_W-1:0] OP_SH  = ALUOP_W'(8'b1110_1001);
   localparam logic [ALUOP_W-1:0] OP_SW  = ALUOP_W'(8'b1110_1011);
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        load_q, load_d, sext_q, sext_d, half_q, half_d, word_q, word_d;
   logic [1:0]  lane_q, lane_d;
   logic [4:0]  wd_q, wd_d;
   logic        bus_req_q, bus_req_d, bus_we_q, bus_we_d;
   logic [31:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
   logic [3:0]  bus_be_q, bus_be_d;
   logic        wb_valid_q, wb_valid_d, wb_wreg_q, wb_wreg_d;
   logic [4:0]  wb_wd_q, wb_wd_d;
   logic [31:0] wb_wdata_q, wb_wdata_d;
   logic        addr_err_q, addr_err_d, bus_err_q, bus_err_d;

   logic        is_load, is_store, is_sext, is_half, is_word, mem_op, misaligned;
   logic        accept_mem, expire;
   logic [3:0]  be_new;
   logic [31:0] wdata_new, load_val;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      is_sext  = 1'b0;
      is_half  = 1'b0;
      is_word  = 1'b0;
      case (aluop_i)
         OP_LB:   begin is_load = 1'b1; is_sext = 1'b1; end
         OP_LBU:  is_load = 1'b1;
         OP_LH:   begin is_load = 1'b1; is_sext = 1'b1; is_half = 1'b1; end
         OP_LHU:  begin is_load = 1'b1; is_half = 1'b1; end
         OP_LW:   begin is_load = 1'b1; is_word = 1'b1; end
         OP_SB:   is_store = 1'b1;
         OP_SH:   begin is_store = 1'b1; is_half = 1'b1; end
         OP_SW:   begin is_store = 1'b1; is_word = 1'b1; end
         default: ;
      endcase
   end

   assign mem_op     = is_load || is_store;
   assign misaligned = (is_half && mem_addr_i[0]) || (is_word && (mem_addr_i[1:0] != 2'b00));
   assign be_new     = is_word ? 4'b1111 :
                       is_half ? (mem_addr_i[1] ? 4'b1100 : 4'b0011) :
                                 (4'b0001 << mem_addr_i[1:0]);
   assign wdata_new  = is_word ? reg2_i :
                       is_half ? {2{reg2_i[15:0]}} : {4{reg2_i[7:0]}};

   assign accept_mem = (state_q == S_IDLE) && valid_i && mem_op && !misaligned;
   // Ack on the expiry cycle takes precedence over the abort.
   assign expire     = (state_q == S_WAIT) && !bus_ack_i && (cnt_q == CNT_LAST);

   assign rd_byte  = 8'(bus_rdata_i >> {lane_q, 3'b000});
   assign rd_half  = lane_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
   assign load_val = word_q ? bus_rdata_i :
                     half_q ? {{16{sext_q & rd_half[15]}}, rd_half} :
                              {{24{sext_q & rd_byte[7]}}, rd_byte};

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept_mem) state_d = S_WAIT;
         S_WAIT:  if (bus_ack_i || expire) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Stall also drops on expiry so the aborted slot advances instead of being re-issued.
   always_comb begin
      stall_o = 1'b0;
      case (state_q)
         S_IDLE:  stall_o = accept_mem;
         S_WAIT:  stall_o = !(bus_ack_i || expire);
         default: stall_o = 1'b0;
      endcase
   end

   always_comb begin
      cnt_d       = cnt_q;
      load_d      = load_q;
      sext_d      = sext_q;
      half_d      = half_q;
      word_d      = word_q;
      lane_d      = lane_q;
      wd_d        = wd_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_be_d    = bus_be_q;
      bus_wdata_d = bus_wdata_q;
      wb_valid_d  = 1'b0;
      wb_wreg_d   = 1'b0;
      wb_wd_d     = wb_wd_q;
      wb_wdata_d  = wb_wdata_q;
      addr_err_d  = 1'b0;
      bus_err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (valid_i && !mem_op) begin
               wb_valid_d = 1'b1;
               wb_wd_d    = wd_i;
               wb_wreg_d  = wreg_i;
               wb_wdata_d = wdata_i;
            end else if (valid_i && misaligned) begin
               wb_valid_d = 1'b1;
               wb_wd_d    = wd_i;
               wb_wdata_d = '0;
               addr_err_d = 1'b1;
            end else if (accept_mem) begin
               cnt_d       = '0;
               load_d      = is_load;
               sext_d      = is_sext;
               half_d      = is_half;
               word_d      = is_word;
               lane_d      = mem_addr_i[1:0];
               wd_d        = wd_i;
               bus_req_d   = 1'b1;
               bus_we_d    = is_store;
               bus_addr_d  = {mem_addr_i[31:2], 2'b00};
               bus_be_d    = be_new;
               bus_wdata_d = wdata_new;
            end
         end
         S_WAIT: begin
            if (bus_ack_i || expire) begin
               bus_req_d   = 1'b0;
               bus_we_d    = 1'b0;
               bus_addr_d  = '0;
               bus_be_d    = '0;
               bus_wdata_d = '0;
               wb_valid_d  = 1'b1;
               wb_wd_d     = wd_q;
               wb_wreg_d   = bus_ack_i && load_q;
               wb_wdata_d  = (bus_ack_i && load_q) ? load_val : 32'h0;
               bus_err_d   = !bus_ack_i;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         load_q      <= 1'b0;
         sext_q      <= 1'b0;
         half_q      <= 1'b0;
         word_q      <= 1'b0;
         lane_q      <= '0;
         wd_q        <= '0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_be_q    <= '0;
         bus_wdata_q <= '0;
         wb_valid_q  <= 1'b0;
         wb_wreg_q   <= 1'b0;
         wb_wd_q     <= '0;
         wb_wdata_q  <= '0;
         addr_err_q  <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         load_q      <= load_d;
         sext_q      <= sext_d;
         half_q      <= half_d;
         word_q      <= word_d;
         lane_q      <= lane_d;
         wd_q        <= wd_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_be_q    <= bus_be_d;
         bus_wdata_q <= bus_wdata_d;
         wb_valid_q  <= wb_valid_d;
         wb_wreg_q   <= wb_wreg_d;
         wb_wd_q     <= wb_wd_d;
         wb_wdata_q  <= wb_wdata_d;
         addr_err_q  <= addr_err_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign bus_req_o   = bus_req_q;
   assign bus_we_o    = bus_we_q;
   assign bus_addr_o  = bus_addr_q;
   assign bus_be_o    = bus_be_q;
   assign bus_wdata_o = bus_wdata_q;
   assign wb_valid_o  = wb_valid_q;
   assign wb_wd_o     = wb_wd_q;
   assign wb_wreg_o   = wb_wreg_q;
   assign wb_wdata_o  = wb_wdata_q;
   assign addr_err_o  = addr_err_q;
   assign bus_err_o   = bus_err_q;

endmodule
